// File: rtl/eth_rx_frame_filter.sv
// Byte-wide Ethernet RX parser: strips preamble/SFD, filters on destination MAC, checks FCS,
// and stores post-EtherType bytes into a ring of fixed-size memory slots.
module eth_rx_frame_filter #(
  parameter logic [47:0] LOCAL_MAC    = 48'h1A2B3C4D5E6F,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter int          SLOT_BITS    = 10,
  parameter int          SLOT_IDX_W   = 6,
  parameter int          ADDR_W       = SLOT_BITS + SLOT_IDX_W
) (
  input  logic                  i_eth_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_dv,
  input  logic                  i_rx_er,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_promisc,
  input  logic                  i_slot_release,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_wr_addr,
  output logic [7:0]            o_mem_wr_data,
  output logic                  o_frame_valid,
  output logic [SLOT_IDX_W-1:0] o_frame_slot,
  output logic [SLOT_BITS:0]    o_frame_len,
  output logic [15:0]           o_ethertype,
  output logic                  o_busy,
  output logic [SLOT_IDX_W:0]   o_slots_used,
  output logic [15:0]           o_drop_count
);

  localparam logic [SLOT_IDX_W:0] SLOTS_FULL  = (SLOT_IDX_W+1)'(2**SLOT_IDX_W);
  localparam logic [SLOT_BITS:0]  SLOT_SIZE   = (SLOT_BITS+1)'(2**SLOT_BITS);
  localparam logic [SLOT_BITS:0]  FCS_LEN     = (SLOT_BITS+1)'(4);
  localparam logic [31:0]         CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DST  = 3'd2;
  localparam logic [2:0] S_SRC  = 3'd3;
  localparam logic [2:0] S_TYPE = 3'd4;
  localparam logic [2:0] S_PAY  = 3'd5;
  localparam logic [2:0] S_CHK  = 3'd6;
  localparam logic [2:0] S_WAIT = 3'd7;

  // Reflected CRC-32, one byte consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  logic [2:0]            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [47:0]           dst_q, dst_d;
  logic [15:0]           etype_q, etype_d;
  logic [31:0]           crc_q, crc_d;
  logic                  er_q, er_d;
  logic [SLOT_BITS:0]    offset_q, offset_d;
  logic [SLOT_IDX_W-1:0] wr_slot_q, wr_slot_d;
  logic [SLOT_IDX_W-1:0] rd_slot_q, rd_slot_d;
  logic [SLOT_IDX_W:0]   used_q, used_d;
  logic [15:0]           drops_q, drops_d;
  logic                  busy_q, busy_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [7:0]            wdata_q, wdata_d;

  logic [47:0] mac_full;
  logic        mac_ok, good, commit, drop, rel_ok;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dst_d     = dst_q;
    etype_d   = etype_q;
    crc_d     = crc_q;
    er_d      = er_q;
    offset_d  = offset_q;
    busy_d    = busy_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    commit    = 1'b0;
    drop      = 1'b0;
    mac_full  = {dst_q[39:0], i_rx_data};
    mac_ok    = i_promisc || (mac_full == LOCAL_MAC) || (ACCEPT_BCAST && (mac_full == '1));
    good      = (crc_q == CRC_RESIDUE) && !er_q && (offset_q >= FCS_LEN);

    // CRC and error tracking cover every byte from the first DST byte on.
    if (i_rx_dv && (state_q inside {S_DST, S_SRC, S_TYPE, S_PAY})) begin
      crc_d = crc32_byte(crc_q, i_rx_data);
      er_d  = er_q | i_rx_er;
    end

    case (state_q)
      S_IDLE: if (i_rx_dv && i_rx_data == 8'h55) state_d = S_PRE;
      S_PRE: begin
        if (!i_rx_dv) state_d = S_IDLE;
        else if (i_rx_data == 8'hD5) begin
          state_d = S_DST;
          busy_d  = 1'b1;
          cnt_d   = 3'd0;
          crc_d   = 32'hFFFFFFFF;
          er_d    = i_rx_er;
        end else if (i_rx_data != 8'h55) state_d = S_WAIT;
      end
      S_DST, S_SRC, S_TYPE: begin
        if (!i_rx_dv) begin
          // Truncated header after SFD: treat as a dropped frame.
          state_d = S_IDLE;
          busy_d  = 1'b0;
          drop    = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (state_q == S_DST) begin
            dst_d = mac_full;
            if (cnt_q == 3'd5) begin
              cnt_d = 3'd0;
              if (mac_ok) state_d = S_SRC;
              else begin
                state_d = S_WAIT;
                drop    = 1'b1;
              end
            end
          end else if (state_q == S_SRC) begin
            if (cnt_q == 3'd5) begin
              cnt_d   = 3'd0;
              state_d = S_TYPE;
            end
          end else begin
            etype_d = {etype_q[7:0], i_rx_data};
            if (cnt_q == 3'd1) begin
              cnt_d = 3'd0;
              if (used_q == SLOTS_FULL) begin
                state_d = S_WAIT;
                drop    = 1'b1;
              end else begin
                state_d  = S_PAY;
                offset_d = '0;
              end
            end
          end
        end
      end
      S_PAY: begin
        if (!i_rx_dv) state_d = S_CHK;
        else if (offset_q == SLOT_SIZE) begin
          state_d = S_WAIT;
          drop    = 1'b1;
        end else begin
          we_d     = 1'b1;
          waddr_d  = {wr_slot_q, offset_q[SLOT_BITS-1:0]};
          wdata_d  = i_rx_data;
          offset_d = offset_q + 1'b1;
        end
      end
      S_CHK: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        commit  = good;
        drop    = !good;
      end
      default: if (!i_rx_dv) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    rel_ok    = i_slot_release && (used_q != '0);
    wr_slot_d = commit ? wr_slot_q + 1'b1 : wr_slot_q;
    rd_slot_d = rel_ok ? rd_slot_q + 1'b1 : rd_slot_q;
    used_d    = used_q;
    if (commit && !rel_ok) used_d = used_q + 1'b1;
    else if (!commit && rel_ok) used_d = used_q - 1'b1;
    drops_d = (drop && drops_q != 16'hFFFF) ? drops_q + 16'd1 : drops_q;
  end

  always_ff @(posedge i_eth_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dst_q     <= '0;
      etype_q   <= '0;
      crc_q     <= '0;
      er_q      <= 1'b0;
      offset_q  <= '0;
      wr_slot_q <= '0;
      rd_slot_q <= '0;
      used_q    <= '0;
      drops_q   <= '0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dst_q     <= dst_d;
      etype_q   <= etype_d;
      crc_q     <= crc_d;
      er_q      <= er_d;
      offset_q  <= offset_d;
      wr_slot_q <= wr_slot_d;
      rd_slot_q <= rd_slot_d;
      used_q    <= used_d;
      drops_q   <= drops_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign o_mem_we      = we_q;
  assign o_mem_wr_addr = waddr_q;
  assign o_mem_wr_data = wdata_q;
  assign o_frame_valid = commit;
  assign o_frame_slot  = wr_slot_q;
  assign o_frame_len   = commit ? offset_q - FCS_LEN : '0;
  assign o_ethertype   = etype_q;
  assign o_busy        = busy_q;
  assign o_slots_used  = used_q;
  assign o_drop_count  = drops_q;

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// Bench for eth_rx_frame_filter: directed vector table, slot-ring and reset corner cases,
// then random frames checked against a frame-level reference model.
module tb_eth_rx_frame_filter;
  localparam logic [47:0] LMAC  = 48'h1A2B3C4D5E6F;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0, rst = 1'b1, dv = 1'b0, er = 1'b0, promisc = 1'b0, rel = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        mem_we, frame_valid, busy;
  logic [15:0] wr_addr, ethertype, drop_count;
  logic [7:0]  wr_data;
  logic [5:0]  frame_slot;
  logic [10:0] frame_len;
  logic [6:0]  slots_used;

  eth_rx_frame_filter dut (
    .i_eth_clk(clk), .i_rst(rst), .i_rx_dv(dv), .i_rx_er(er), .i_rx_data(data),
    .i_promisc(promisc), .i_slot_release(rel),
    .o_mem_we(mem_we), .o_mem_wr_addr(wr_addr), .o_mem_wr_data(wr_data),
    .o_frame_valid(frame_valid), .o_frame_slot(frame_slot), .o_frame_len(frame_len),
    .o_ethertype(ethertype), .o_busy(busy), .o_slots_used(slots_used), .o_drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          fv_cnt = 0;
  logic [5:0]  fv_slot;
  logic [10:0] fv_len;
  logic [15:0] fv_type;

  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (frame_valid) begin
      fv_cnt  = fv_cnt + 1;
      fv_slot = frame_slot;
      fv_len  = frame_len;
      fv_type = ethertype;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic bq_t build(input logic [47:0] dst, input logic [15:0] et,
                                input int plen, input bit bad_fcs);
    bq_t f;
    logic [31:0] c, fcs;
    for (int i = 0; i < 6; i++) f.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(8'h10 + 8'(i));
    f.push_back(et[15:8]);
    f.push_back(et[7:0]);
    for (int i = 0; i < plen; i++) f.push_back(8'($urandom()));
    c = 32'hFFFFFFFF;
    foreach (f[i])
      for (int b = 0; b < 8; b++)
        c = (c[0] ^ f[i][b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    fcs = ~c;
    if (bad_fcs) fcs = fcs ^ 32'h00000100;
    for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
    return f;
  endfunction

  task automatic send(input bq_t fr, input int er_at, input bit rel_chk);
    wa_q.delete();
    wd_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      dv = 1'b1; er = 1'b0; data = (i == 7) ? 8'hD5 : 8'h55;
    end
    foreach (fr[i]) begin
      @(posedge clk); #1;
      data = fr[i]; er = (i == er_at);
    end
    @(posedge clk); #1;
    dv = 1'b0; er = 1'b0; data = 8'h00;
    @(posedge clk); #1;
    rel = rel_chk;
    @(posedge clk); #1;
    rel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_slot();
    @(posedge clk); #1; rel = 1'b1;
    @(posedge clk); #1; rel = 1'b0;
  endtask

  task automatic chk_writes(input string nm, input bq_t fr, input int n, input logic [15:0] base);
    bit ok;
    ok = (wa_q.size() == n);
    chk({nm, "_nwr"}, wa_q.size(), n);
    if (ok)
      for (int i = 0; i < n; i++)
        if (wa_q[i] !== base + 16'(i) || wd_q[i] !== fr[14+i]) ok = 1'b0;
    if (n > 0) chk({nm, "_wrdat"}, {63'd0, ok}, 64'd1);
  endtask

  typedef struct {
    logic [47:0] dst; bit promisc; logic [15:0] et; int plen; bit bad_fcs; int er_at;
    bit exp_valid; logic [5:0] exp_slot; logic [10:0] exp_len; int exp_wr;
    logic [15:0] exp_base; logic [15:0] exp_drops; logic [6:0] exp_used;
  } vec_t;

  vec_t tv[8];

  initial begin
    bq_t fr;
    int  v0, m_used, m_slot, m_drops;
    bit  ok;

    tv[0] = '{BCAST, 1'b0, 16'h0800, 46, 1'b0, -1, 1'b1, 6'd0, 11'd46, 50, 16'h0000, 16'd0, 7'd1};
    tv[1] = '{48'h020000000001, 1'b0, 16'h0800, 46, 1'b0, -1, 1'b0, 6'd0, 11'd0, 0, 16'h0000, 16'd1, 7'd1};
    tv[2] = '{48'h020000000001, 1'b1, 16'h0800, 46, 1'b0, -1, 1'b1, 6'd1, 11'd46, 50, 16'h0400, 16'd1, 7'd2};
    tv[3] = '{LMAC, 1'b0, 16'h0800, 46, 1'b1, -1, 1'b0, 6'd0, 11'd0, 50, 16'h0800, 16'd2, 7'd2};
    tv[4] = '{LMAC, 1'b0, 16'h0800, 46, 1'b0, 24, 1'b0, 6'd0, 11'd0, 50, 16'h0800, 16'd3, 7'd2};
    tv[5] = '{LMAC, 1'b0, 16'h86DD, 60, 1'b0, -1, 1'b1, 6'd2, 11'd60, 64, 16'h0800, 16'd3, 7'd3};
    tv[6] = '{LMAC, 1'b0, 16'h0800, 1100, 1'b0, -1, 1'b0, 6'd0, 11'd0, 1024, 16'h0C00, 16'd4, 7'd3};
    tv[7] = '{LMAC, 1'b0, 16'h0806, 0, 1'b0, -1, 1'b1, 6'd3, 11'd0, 4, 16'h0C00, 16'd4, 7'd4};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_used", slots_used, 0);
    chk("rst_drops", drop_count, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_valid", frame_valid, 0);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      promisc = tv[k].promisc;
      fr = build(tv[k].dst, tv[k].et, tv[k].plen, tv[k].bad_fcs);
      v0 = fv_cnt;
      send(fr, tv[k].er_at, 1'b0);
      chk($sformatf("v%0d_valid", k), fv_cnt - v0, tv[k].exp_valid);
      if (tv[k].exp_valid) begin
        chk($sformatf("v%0d_slot", k), fv_slot, tv[k].exp_slot);
        chk($sformatf("v%0d_len", k), fv_len, tv[k].exp_len);
        chk($sformatf("v%0d_type", k), fv_type, tv[k].et);
      end
      chk($sformatf("v%0d_drops", k), drop_count, tv[k].exp_drops);
      chk($sformatf("v%0d_used", k), slots_used, tv[k].exp_used);
      chk($sformatf("v%0d_busy", k), busy, 0);
      chk_writes($sformatf("v%0d", k), fr, tv[k].exp_wr, tv[k].exp_base);
    end
    promisc = 1'b0;

    // Ring fill: empty the ring, then 64 commits starting at slot 4 must wrap 63 -> 0.
    repeat (4) release_slot();
    chk("ring_empty", slots_used, 0);
    ok = 1'b1;
    for (int i = 0; i < 64; i++) begin
      fr = build(LMAC, 16'h0800, 2, 1'b0);
      v0 = fv_cnt;
      send(fr, -1, 1'b0);
      if (fv_cnt - v0 != 1 || fv_slot !== 6'((4 + i) % 64)) ok = 1'b0;
    end
    chk("ring_wrap_slots", {63'd0, ok}, 64'd1);
    chk("ring_full_used", slots_used, 64);
    fr = build(LMAC, 16'h0800, 2, 1'b0);
    v0 = fv_cnt;
    send(fr, -1, 1'b0);
    chk("full_valid", fv_cnt - v0, 0);
    chk("full_drops", drop_count, 5);
    chk("full_nwr", wa_q.size(), 0);
    chk("full_used", slots_used, 64);
    release_slot();
    chk("rel_used", slots_used, 63);
    fr = build(LMAC, 16'h0800, 3, 1'b0);
    v0 = fv_cnt;
    send(fr, -1, 1'b1);
    chk("simul_valid", fv_cnt - v0, 1);
    chk("simul_slot", fv_slot, 4);
    chk("simul_used", slots_used, 63);
    fr = build(LMAC, 16'h0800, 3, 1'b0);
    send(fr, -1, 1'b0);
    chk("refill_slot", fv_slot, 5);
    chk("refill_used", slots_used, 64);

    // Asynchronous reset in the middle of a payload.
    fr = build(LMAC, 16'h0800, 30, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      dv = 1'b1; data = (i == 7) ? 8'hD5 : 8'h55;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      data = fr[i];
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_addr", wr_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_used", slots_used, 0);
    chk("mid_rst_drops", drop_count, 0);
    dv = 1'b0; data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    fr = build(LMAC, 16'h0800, 10, 1'b0);
    v0 = fv_cnt;
    send(fr, -1, 1'b0);
    chk("post_rst_valid", fv_cnt - v0, 1);
    chk("post_rst_slot", fv_slot, 0);
    chk_writes("post_rst", fr, 14, 16'h0000);

    // Random frames against a frame-level model of the slot ring and drop counter.
    m_used = 1; m_slot = 1; m_drops = 0;
    for (int k = 0; k < 40; k++) begin
      logic [63:0] rnd;
      logic [47:0] dst;
      int plen, er_at, n_wr;
      bit bad, dst_ok, exp_commit;
      if ($urandom_range(1, 0) == 1) begin
        release_slot();
        if (m_used > 0) m_used--;
      end
      rnd = {$urandom(), $urandom()};
      case ($urandom_range(3, 0))
        0: dst = LMAC;
        1: dst = BCAST;
        default: dst = rnd[47:0];
      endcase
      promisc = ($urandom_range(3, 0) == 0);
      plen = ($urandom_range(9, 0) == 0) ? 1030 : int'($urandom_range(60, 0));
      bad  = ($urandom_range(4, 0) == 0);
      fr = build(dst, 16'(k * 7 + 16'h0600), plen, bad);
      er_at = ($urandom_range(9, 0) == 0) ? int'($urandom_range(fr.size() - 1, 0)) : -1;

      dst_ok = promisc || dst == LMAC || dst == BCAST;
      exp_commit = 1'b0;
      n_wr = 0;
      if (!dst_ok || m_used == 64) m_drops++;
      else begin
        n_wr = (plen + 4 > 1024) ? 1024 : plen + 4;
        exp_commit = (plen + 4 <= 1024) && !bad && er_at < 0;
        if (!exp_commit) m_drops++;
      end

      v0 = fv_cnt;
      send(fr, er_at, 1'b0);
      chk($sformatf("r%0d_valid", k), fv_cnt - v0, exp_commit);
      if (exp_commit) begin
        chk($sformatf("r%0d_slot", k), fv_slot, m_slot);
        chk($sformatf("r%0d_len", k), fv_len, plen);
        chk($sformatf("r%0d_type", k), fv_type, 16'(k * 7 + 16'h0600));
      end
      chk_writes($sformatf("r%0d", k), fr, n_wr, 16'(m_slot * 1024));
      if (exp_commit) begin
        m_used++;
        m_slot = (m_slot + 1) % 64;
      end
      chk($sformatf("r%0d_drops", k), drop_count, m_drops);
      chk($sformatf("r%0d_used", k), slots_used, m_used);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
